id_stage_fwd: RTL and testbench
===============================

# id_stage_fwd

Parametrised decode stage for the 5-stage MIPS pipeline, sitting between IF and EX. It owns the IF→ID pipeline register and an instruction-hold register so stalls survive synchronous SRAM read data changing. It forwards operands from N_FWD downstream writers by priority and detects load-use hazards, generating its own stall and bubble. It resolves branches in ID with a single architectural delay slot.

## Interface
- DATA_W, 32, register/operand width
- PC_W, 32, program counter width
- N_FWD, 3, forwarding sources; index 0 = EX (highest priority), then MEM, WB
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- if_valid  input  1  IF presents a valid PC this cycle
- if_pc  input  PC_W  PC of the instruction being fetched
- inst_rdata  input  32  instruction SRAM data, valid the cycle after its PC is latched into ID
- ex_stall  input  1  EX cannot accept; ID must hold
- flush  input  1  kill ID contents at next edge
- rf_raddr1 / rf_raddr2  output  5  regfile read addresses (rs / rt of id_inst)
- rf_rdata1 / rf_rdata2  input  DATA_W  regfile read data, combinational
- fwd_we  input  N_FWD  per-source write enable
- fwd_waddr  input  5*N_FWD  per-source destination, source i at [5i+4:5i]
- fwd_wdata  input  DATA_W*N_FWD  per-source result, source i at slice i
- ex_is_load  input  1  source 0 is a load (its fwd_wdata is not yet valid)
- stall_up  output  1  IF must hold its PC
- id_valid_out  output  1  instruction handed to EX this cycle (0 = bubble)
- id_pc  output  PC_W  PC in ID
- id_inst  output  32  instruction in ID
- rs_val / rt_val  output  DATA_W  forwarded operands
- br_taken  output  1  redirect fetch
- br_target  output  PC_W  redirect address

## Operation
- State: id_v, id_pc_r, inst_hold, hold_v. All reset to 0 asynchronously when rst low.
- hold = stallreq | ex_stall. stall_up = hold.
- Register update priority: flush > hold > load. flush: id_v←0, hold_v←0. hold: keep id_v/id_pc_r; if !hold_v capture inst_hold←inst_rdata, hold_v←1. load: id_v←if_valid, id_pc_r←if_pc, hold_v←0.
- id_inst = hold_v ? inst_hold : inst_rdata; id_pc = id_pc_r.
- Use flags: uses_rs = !(lui | j | jal); uses_rt = SPECIAL | beq | bne | sb | sh | sw.
- Forwarding per operand: lowest index i with fwd_we[i] & waddr_i==addr & addr!=0 wins; else regfile data. Address 0 always yields 0.
- stallreq = id_v & ex_is_load & fwd_we[0] & waddr_0!=0 & ((uses_rs & waddr_0==rs) | (uses_rt & waddr_0==rt)).
- id_valid_out = id_v & !stallreq & !flush.
- Branch (only when id_valid_out): beq taken if rs_val==rt_val; target = id_pc + 4 + (sign_ext(imm16)<<2), PC_W arithmetic, wraps modulo 2^PC_W. br_target = 0 when not taken. Delay-slot instruction is never killed by a branch.

## Timing
- Reset: stall_up, id_valid_out, br_taken, br_target, id_pc, id_inst (hold path) all 0; rs_val/rt_val follow combinational inputs.
- Latency: IF→ID 1 cycle; ID outputs combinational from registered state; branch redirect same cycle as branch in ID.
- Load-use: exactly 1 bubble when load is in EX; next cycle load is in MEM and source 1 forwards.
- ex_stall with stallreq together: hold, id_valid_out=0.
- flush during hold: flush wins, hold_v cleared.
- rst asserted mid-stall: all state cleared immediately; no captured instruction survives.
- Multiple matching sources: strictly lowest index; stale WB never overrides EX.

## Configuration
- ID_EXT_BRANCH_EN defined: also resolves bne (!=), bgez/bltz (REGIMM rt=1/0, signed), bgtz/blez (signed vs 0), j/jal (target = {pc+4[PC_W-1:28], index26, 2'b00}); jal treats rs/rt as unused.
- Undefined: only beq; all other opcodes give br_taken=0.

## Test plan
- Reset: rst low mid-run with valid instruction in ID → all registered outputs 0, br_taken=0, id_valid_out=0 within same cycle.
- Forward priority: rs=5, EX/MEM/WB all write r5 with 0x11/0x22/0x33 → rs_val=0x11; drop EX we → 0x22; write to r0 with 0xFF → rs_val=0.
- Load-use: lw r3 in EX (ex_is_load=1), addu r4,r3,r2 in ID → stallreq=1, stall_up=1, id_valid_out=0 for exactly 1 cycle, inst unchanged; next cycle MEM forwards value.
- Hold capture: ex_stall high 3 cycles while inst_rdata changes to garbage → id_inst stays original 0x3C01_1234, advances after release.
- Branch: beq at pc 0xBFC0_0010, imm=0xFFFC, equal operands → br_taken=1, br_target=0xBFC0_0004; unequal → 0.
- Flush vs hold: flush and ex_stall same edge → id_valid_out=0 next cycle, hold_v=0; ID_EXT_BRANCH_EN build: bltz with rs=0x8000_0000 → taken.

Source files
------------

// File: rtl/id_stage_fwd_if.sv
// Forwarding bus from the downstream writers (EX, MEM, WB, ...) into decode.
// Source i owns fwd_we[i], fwd_waddr[5i+4:5i] and fwd_wdata slice i;
// ex_is_load flags that source 0 is a load whose data is not yet valid.
interface id_stage_fwd_if #(
  parameter int DATA_W = 32,
  parameter int N_FWD  = 3
);
  logic [N_FWD-1:0]        fwd_we;
  logic [5*N_FWD-1:0]      fwd_waddr;
  logic [DATA_W*N_FWD-1:0] fwd_wdata;
  logic                    ex_is_load;

  modport master (output fwd_we, fwd_waddr, fwd_wdata, ex_is_load);
  modport slave  (input  fwd_we, fwd_waddr, fwd_wdata, ex_is_load);
endinterface

// File: rtl/id_stage_fwd.sv
// Decode stage of the 5-stage MIPS pipeline.
// Owns the IF->ID register and an instruction-hold register so that a stall
// survives the synchronous instruction SRAM moving on to the next word.
// Forwards operands from N_FWD downstream writers (lowest index wins),
// raises a one-bubble load-use stall and resolves branches in ID with one
// architectural delay slot (the delay-slot instruction is never killed).
// Optional feature: define ID_EXT_BRANCH_EN to also resolve bne, bgez, bltz,
// bgtz, blez, j and jal; without it only beq can redirect fetch.
module id_stage_fwd #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int N_FWD  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [31:0]       inst_rdata,
  input  logic              ex_stall,
  input  logic              flush,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  id_stage_fwd_if.slave     fwd,
  output logic              stall_up,
  output logic              id_valid_out,
  output logic [PC_W-1:0]   id_pc,
  output logic [31:0]       id_inst,
  output logic [DATA_W-1:0] rs_val,
  output logic [DATA_W-1:0] rt_val,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_target
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  logic              id_v_r;
  logic [PC_W-1:0]   id_pc_r;
  logic [31:0]       inst_hold_r;
  logic              hold_v_r;

  logic [5:0]        opcode_s;
  logic [4:0]        rs_s;
  logic [4:0]        rt_s;
  logic              uses_rs_s;
  logic              uses_rt_s;
  logic [4:0]        ex_waddr_s;
  logic              stallreq_s;
  logic              hold_s;
  logic [PC_W-1:0]   pc_plus4_s;
  logic [PC_W-1:0]   br_rel_s;
  logic              taken_s;
  logic [PC_W-1:0]   target_s;

  // Operand select: scan from the lowest-priority source up so the lowest
  // matching index is the last one written; register 0 always reads as 0.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [4:0]              addr,
    input logic [DATA_W-1:0]       rf_data,
    input logic [N_FWD-1:0]        we,
    input logic [5*N_FWD-1:0]      waddr,
    input logic [DATA_W*N_FWD-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    val = rf_data;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      val = (we[i] && (waddr[5*i +: 5] == addr)) ? wdata[DATA_W*i +: DATA_W] : val;
    end
    return (addr == 5'd0) ? {DATA_W{1'b0}} : val;
  endfunction

  // Pipeline register and hold capture: flush beats hold, hold beats load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_v_r      <= 1'b0;
      id_pc_r     <= '0;
      inst_hold_r <= 32'h0000_0000;
      hold_v_r    <= 1'b0;
    end else if (flush) begin
      id_v_r      <= 1'b0;
      hold_v_r    <= 1'b0;
    end else if (hold_s) begin
      if (!hold_v_r) begin
        inst_hold_r <= inst_rdata;
        hold_v_r    <= 1'b1;
      end else begin
        hold_v_r    <= 1'b1;
      end
    end else begin
      id_v_r      <= if_valid;
      id_pc_r     <= if_pc;
      hold_v_r    <= 1'b0;
    end
  end

  // Decode fields, operand forwarding and the load-use hazard check.
  always_comb begin
    id_inst    = hold_v_r ? inst_hold_r : inst_rdata;
    id_pc      = id_pc_r;
    opcode_s   = id_inst[31:26];
    rs_s       = id_inst[25:21];
    rt_s       = id_inst[20:16];
    rf_raddr1  = rs_s;
    rf_raddr2  = rt_s;
    uses_rs_s  = !((opcode_s == OP_LUI) || (opcode_s == OP_J) || (opcode_s == OP_JAL));
    uses_rt_s  = (opcode_s == OP_SPECIAL) || (opcode_s == OP_BEQ) || (opcode_s == OP_BNE) ||
                 (opcode_s == OP_SB) || (opcode_s == OP_SH) || (opcode_s == OP_SW);
    rs_val     = fwd_sel(rs_s, rf_rdata1, fwd.fwd_we, fwd.fwd_waddr, fwd.fwd_wdata);
    rt_val     = fwd_sel(rt_s, rf_rdata2, fwd.fwd_we, fwd.fwd_waddr, fwd.fwd_wdata);
    ex_waddr_s = fwd.fwd_waddr[4:0];
    stallreq_s = id_v_r && fwd.ex_is_load && fwd.fwd_we[0] && (ex_waddr_s != 5'd0) &&
                 ((uses_rs_s && (ex_waddr_s == rs_s)) || (uses_rt_s && (ex_waddr_s == rt_s)));
    hold_s       = stallreq_s || ex_stall;
    stall_up     = hold_s;
    id_valid_out = id_v_r && !stallreq_s && !flush;
  end

  // Branch resolution; only an instruction actually handed to EX may redirect.
  always_comb begin
    pc_plus4_s = id_pc_r + PC_W'(4);
    br_rel_s   = pc_plus4_s + {{(PC_W-18){id_inst[15]}}, id_inst[15:0], 2'b00};
    taken_s    = 1'b0;
    target_s   = br_rel_s;
    case (opcode_s)
      OP_BEQ:    taken_s = (rs_val == rt_val);
`ifdef ID_EXT_BRANCH_EN
      OP_BNE:    taken_s = (rs_val != rt_val);
      OP_REGIMM: begin
        case (rt_s)
          5'd0:    taken_s = rs_val[DATA_W-1];
          5'd1:    taken_s = !rs_val[DATA_W-1];
          default: taken_s = 1'b0;
        endcase
      end
      OP_BGTZ:   taken_s = !rs_val[DATA_W-1] && (rs_val != {DATA_W{1'b0}});
      OP_BLEZ:   taken_s = rs_val[DATA_W-1] || (rs_val == {DATA_W{1'b0}});
      OP_J, OP_JAL: begin
        taken_s  = 1'b1;
        target_s = {pc_plus4_s[PC_W-1:28], id_inst[25:0], 2'b00};
      end
`endif
      default:   taken_s = 1'b0;
    endcase
    br_taken  = id_valid_out && taken_s;
    br_target = br_taken ? target_s : '0;
  end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: a table of single-instruction vectors
// followed by hand-written multi-cycle sequences (hold capture, load-use,
// flush against hold, reset during a stall).
module tb_id_stage_fwd;

`ifdef ID_EXT_BRANCH_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic [31:0] inst_rdata = 32'h0;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1 = 32'h0;
  logic [31:0] rf_rdata2 = 32'h0;
  logic        stall_up, id_valid_out, br_taken;
  logic [31:0] id_pc, id_inst, rs_val, rt_val, br_target;

  id_stage_fwd_if #(.DATA_W(32), .N_FWD(3)) fbus ();

  id_stage_fwd #(.DATA_W(32), .PC_W(32), .N_FWD(3)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
    .inst_rdata(inst_rdata), .ex_stall(ex_stall), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd(fbus),
    .stall_up(stall_up), .id_valid_out(id_valid_out), .id_pc(id_pc),
    .id_inst(id_inst), .rs_val(rs_val), .rt_val(rt_val),
    .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [2:0]  we;
    logic [14:0] waddr;
    logic [95:0] wdata;
    logic        ld;
    logic        exs;
    logic        fl;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_br;
    logic [31:0] e_tgt;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic clear_side();
    fbus.fwd_we     = 3'b000;
    fbus.fwd_waddr  = 15'h0;
    fbus.fwd_wdata  = 96'h0;
    fbus.ex_is_load = 1'b0;
    ex_stall        = 1'b0;
    flush           = 1'b0;
  endtask

  // Present a PC to ID with no hold pending and let one edge load it.
  task automatic load_id(input logic v, input logic [31:0] pc);
    clear_side();
    if_valid = v;
    if_pc    = pc;
    @(posedge clk);
    #1;
    if_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_side();
    //           ifv   pc            inst          rf1           rf2           we      waddr {s2,s1,s0}       wdata {s2,s1,s0}                        ld    exs   fl    stall valid e_rs          e_rt          br    tgt
    vt[0]  = '{1'b1, 32'h0000_0100, 32'h00A7_3021, 32'h0000_AAAA, 32'h0000_7777, 3'b111, {5'd5, 5'd5, 5'd5}, {32'h33, 32'h22, 32'h11},               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 32'h0000_7777, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 32'h0000_0104, 32'h00A7_3021, 32'h0000_AAAA, 32'h0000_7777, 3'b110, {5'd5, 5'd5, 5'd5}, {32'h33, 32'h22, 32'h11},               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0022, 32'h0000_7777, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 32'h0000_0108, 32'h00A7_3021, 32'h0000_AAAA, 32'h0000_7777, 3'b100, {5'd5, 5'd5, 5'd5}, {32'h33, 32'h22, 32'h11},               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0033, 32'h0000_7777, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 32'h0000_010C, 32'h00A7_3021, 32'h0000_AAAA, 32'h0000_7777, 3'b000, {5'd5, 5'd5, 5'd5}, {32'h33, 32'h22, 32'h11},               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_AAAA, 32'h0000_7777, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 32'h0000_0110, 32'h0007_3021, 32'h0000_DEAD, 32'h0000_7777, 3'b111, {5'd0, 5'd0, 5'd0}, {32'hFF, 32'hFF, 32'hFF},               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_7777, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 32'h0000_0114, 32'h0062_2021, 32'h0000_1111, 32'h0000_2222, 3'b110, {5'd3, 5'd2, 5'd0}, {32'h66, 32'h55, 32'h00},               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0066, 32'h0000_0055, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 32'hBFC0_0010, 32'h1022_FFFC, 32'h0000_1234, 32'h0000_1234, 3'b000, 15'h0,              96'h0,                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1, 32'hBFC0_0004};
    vt[7]  = '{1'b1, 32'hBFC0_0010, 32'h1022_FFFC, 32'h0000_1234, 32'h0000_1235, 3'b000, 15'h0,              96'h0,                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_1235, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 32'h0000_0100, 32'h1022_0003, 32'h0000_0001, 32'h0000_0002, 3'b001, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h1},                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0110};
    vt[9]  = '{1'b1, 32'h0000_0300, 32'h0062_2021, 32'h0000_0001, 32'h0000_0002, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'hBAD},               1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0BAD, 32'h0000_0002, 1'b0, 32'h0};
    vt[10] = '{1'b1, 32'hBFC0_0010, 32'h1022_FFFC, 32'h0000_0005, 32'h0000_0005, 3'b001, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h5},                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0};
    vt[11] = '{1'b1, 32'h0000_0120, 32'h3C01_1234, 32'h0000_0000, 32'h0000_0000, 3'b001, {5'd0, 5'd0, 5'd1}, {32'h0, 32'h0, 32'h99},                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0099, 1'b0, 32'h0};
    vt[12] = '{1'b1, 32'h0000_0124, 32'hAC62_0000, 32'h0000_0010, 32'h0000_0020, 3'b001, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h77},                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0077, 1'b0, 32'h0};
    vt[13] = '{1'b1, 32'hBFC0_0010, 32'h1022_FFFC, 32'h0000_0007, 32'h0000_0007, 3'b000, 15'h0,              96'h0,                                  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0007, 1'b1, 32'hBFC0_0004};
    vt[14] = '{1'b1, 32'hBFC0_0010, 32'h1022_FFFC, 32'h0000_0007, 32'h0000_0007, 3'b000, 15'h0,              96'h0,                                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0007, 1'b0, 32'h0};
    vt[15] = '{1'b0, 32'hBFC0_0010, 32'h1022_FFFC, 32'h0000_0007, 32'h0000_0007, 3'b000, 15'h0,              96'h0,                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0007, 1'b0, 32'h0};
    vt[16] = '{1'b1, 32'h0000_0130, 32'h0007_3021, 32'h0000_0001, 32'h0000_0042, 3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h5},                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0042, 1'b0, 32'h0};
    vt[17] = '{1'b1, 32'h0000_1000, 32'h0420_0004, 32'h8000_0000, 32'h0000_0000, 3'b000, 15'h0,              96'h0,                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, EXT,  EXT ? 32'h0000_1014 : 32'h0};
    vt[18] = '{1'b1, 32'hA000_0000, 32'h0800_0100, 32'h0000_0000, 32'h0000_0000, 3'b000, 15'h0,              96'h0,                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, EXT,  EXT ? 32'hA000_0400 : 32'h0};
    vt[19] = '{1'b1, 32'h0000_2000, 32'h1422_0001, 32'h0000_0001, 32'h0000_0002, 3'b000, 15'h0,              96'h0,                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0002, EXT,  EXT ? 32'h0000_2008 : 32'h0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_stall_up", {31'h0, stall_up}, 32'h0);
    chk("rst_valid", {31'h0, id_valid_out}, 32'h0);
    chk("rst_br_taken", {31'h0, br_taken}, 32'h0);
    chk("rst_br_target", br_target, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    rst = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      load_id(vt[i].ifv, vt[i].pc);
      inst_rdata      = vt[i].inst;
      rf_rdata1       = vt[i].rf1;
      rf_rdata2       = vt[i].rf2;
      fbus.fwd_we     = vt[i].we;
      fbus.fwd_waddr  = vt[i].waddr;
      fbus.fwd_wdata  = vt[i].wdata;
      fbus.ex_is_load = vt[i].ld;
      ex_stall        = vt[i].exs;
      flush           = vt[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_stall_up", i), {31'h0, stall_up}, {31'h0, vt[i].e_stall});
      chk($sformatf("v%0d_valid", i), {31'h0, id_valid_out}, {31'h0, vt[i].e_valid});
      chk($sformatf("v%0d_rs_val", i), rs_val, vt[i].e_rs);
      chk($sformatf("v%0d_rt_val", i), rt_val, vt[i].e_rt);
      chk($sformatf("v%0d_br_taken", i), {31'h0, br_taken}, {31'h0, vt[i].e_br});
      chk($sformatf("v%0d_br_target", i), br_target, vt[i].e_tgt);
      chk($sformatf("v%0d_id_pc", i), id_pc, vt[i].pc);
      chk($sformatf("v%0d_raddr", i), {22'h0, rf_raddr1, rf_raddr2}, {22'h0, vt[i].inst[25:21], vt[i].inst[20:16]});
    end

    // Hold capture: three stalled cycles with the SRAM returning garbage.
    load_id(1'b1, 32'h0000_0200);
    inst_rdata = 32'h3C01_1234;
    ex_stall   = 1'b1;
    @(negedge clk);
    chk("hold_c1_inst", id_inst, 32'h3C01_1234);
    chk("hold_c1_stall_up", {31'h0, stall_up}, 32'h1);
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk);
      #1;
      inst_rdata = 32'hDEAD_BEEF + 32'(c);
      @(negedge clk);
      chk($sformatf("hold_c%0d_inst", c), id_inst, 32'h3C01_1234);
      chk($sformatf("hold_c%0d_pc", c), id_pc, 32'h0000_0200);
    end
    @(posedge clk);
    #1;
    ex_stall = 1'b0;
    if_valid = 1'b1;
    if_pc    = 32'h0000_0204;
    @(negedge clk);
    chk("hold_c4_inst", id_inst, 32'h3C01_1234);
    chk("hold_c4_valid", {31'h0, id_valid_out}, 32'h1);
    @(posedge clk);
    #1;
    if_valid   = 1'b0;
    inst_rdata = 32'h0062_2021;
    @(negedge clk);
    chk("hold_rel_pc", id_pc, 32'h0000_0204);
    chk("hold_rel_inst", id_inst, 32'h0062_2021);

    // Load-use: one bubble, then the load result forwards from MEM.
    load_id(1'b1, 32'h0000_0300);
    inst_rdata      = 32'h0062_2021;
    rf_rdata1       = 32'h0000_1111;
    rf_rdata2       = 32'h0000_2222;
    fbus.ex_is_load = 1'b1;
    fbus.fwd_we     = 3'b001;
    fbus.fwd_waddr  = {5'd0, 5'd0, 5'd3};
    fbus.fwd_wdata  = 96'h0;
    @(negedge clk);
    chk("lu_c1_stall_up", {31'h0, stall_up}, 32'h1);
    chk("lu_c1_valid", {31'h0, id_valid_out}, 32'h0);
    @(posedge clk);
    #1;
    inst_rdata      = 32'hFFFF_FFFF;
    fbus.ex_is_load = 1'b0;
    fbus.fwd_we     = 3'b010;
    fbus.fwd_waddr  = {5'd0, 5'd3, 5'd0};
    fbus.fwd_wdata  = {32'h0, 32'h0000_CAFE, 32'h0};
    @(negedge clk);
    chk("lu_c2_stall_up", {31'h0, stall_up}, 32'h0);
    chk("lu_c2_valid", {31'h0, id_valid_out}, 32'h1);
    chk("lu_c2_inst", id_inst, 32'h0062_2021);
    chk("lu_c2_pc", id_pc, 32'h0000_0300);
    chk("lu_c2_rs_val", rs_val, 32'h0000_CAFE);
    chk("lu_c2_rt_val", rt_val, 32'h0000_2222);

    // Flush and ex_stall on the same edge: flush wins and drops the hold.
    load_id(1'b1, 32'h0000_0400);
    inst_rdata = 32'h3C01_1234;
    ex_stall   = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    chk("fl_c1_valid", {31'h0, id_valid_out}, 32'h0);
    @(posedge clk);
    #1;
    ex_stall   = 1'b0;
    flush      = 1'b0;
    inst_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("fl_c2_valid", {31'h0, id_valid_out}, 32'h0);
    chk("fl_c2_inst", id_inst, 32'h1234_5678);

    // Reset asserted mid-stall with a taken branch captured in ID.
    load_id(1'b1, 32'h0000_0500);
    inst_rdata = 32'h1022_FFFC;
    rf_rdata1  = 32'h0000_0003;
    rf_rdata2  = 32'h0000_0003;
    ex_stall   = 1'b1;
    @(negedge clk);
    chk("rs_pre_br_taken", {31'h0, br_taken}, 32'h1);
    chk("rs_pre_br_target", br_target, 32'h0000_04F4);
    @(posedge clk);
    #1;
    inst_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rs_hold_inst", id_inst, 32'h1022_FFFC);
    #2;
    rst      = 1'b0;
    ex_stall = 1'b0;
    #1;
    chk("rs_mid_id_pc", id_pc, 32'h0);
    chk("rs_mid_valid", {31'h0, id_valid_out}, 32'h0);
    chk("rs_mid_br_taken", {31'h0, br_taken}, 32'h0);
    chk("rs_mid_br_target", br_target, 32'h0);
    chk("rs_mid_stall_up", {31'h0, stall_up}, 32'h0);
    chk("rs_mid_inst", id_inst, 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
